mips32_mem_bridge: RTL and testbench

Parametrised data-memory bridge between the MIPS32 core's load/store port and a single-ported synchronous data RAM. It maps N virtual address regions onto one physical word space and inserts configurable wait states. Accesses that hit no region, or are misaligned, are trapped in a sticky fault state. While an access or fault is pending it drives `stall` so the core holds its PC.

---
 rtl/mips32_mem_bridge.sv | 164 ++++++++++++++++
 tb/tb_mips32_mem_bridge.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mips32_mem_bridge
// Brief    : Maps MIPS32 load/store requests onto a single-ported data RAM,
//            with configurable wait states and a sticky fault trap.
// Revision : 1.0 - initial release
// ============================================================================
module mips32_mem_bridge #(
    parameter int                        NUM_REGIONS  = 2,
    parameter int                        REGION_LOG2W = 10,
    parameter int                        PHYS_AW      = 11,
    parameter logic [NUM_REGIONS*32-1:0] REGION_BASE  = {32'h7FFFE000, 32'h10010000},
    parameter int                        WAIT_STATES  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               req_ready,
    output logic               stall,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               fault,
    output logic [31:0]        fault_addr,
    input  logic               fault_clr,
    output logic               mem_en,
    output logic               mem_we,
    output logic [PHYS_AW-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam int                 c_cnt_w        = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_wait_val     = c_cnt_w'(WAIT_STATES);
    localparam logic [32:0]        c_region_bytes = 33'd4 << REGION_LOG2W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [PHYS_AW-1:0]   r_addr;
    logic                 r_write;
    logic [31:0]          r_wdata;
    logic [31:0]          r_fault_addr;

    logic [31:0]          w_off   [NUM_REGIONS];
    logic [PHYS_AW-1:0]   w_rphys [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] w_rhit;
    logic                 w_hit;
    logic [PHYS_AW-1:0]   w_phys;
    logic                 w_valid;

    // Per-region offset and hit; the unsigned subtract folds the lower bound in.
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        localparam logic [PHYS_AW-1:0] c_phys_base = PHYS_AW'(gi) << REGION_LOG2W;
        assign w_off[gi]   = req_addr - REGION_BASE[32*gi +: 32];
        assign w_rhit[gi]  = ({1'b0, w_off[gi]} < c_region_bytes);
        assign w_rphys[gi] = c_phys_base | PHYS_AW'(w_off[gi][REGION_LOG2W+1:2]);
    end

    // Scan downwards so the lowest-indexed hitting region wins.
    always_comb begin
        w_hit  = 1'b0;
        w_phys = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_rhit[i]) begin
                w_hit  = 1'b1;
                w_phys = w_rphys[i];
            end
        end
    end

    assign w_valid = w_hit && (req_addr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_fault_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                if (w_valid) begin
                    r_addr  <= w_phys;
                    r_write <= req_write;
                    r_wdata <= req_wdata;
                    r_cnt   <= c_wait_val;
                end else begin
                    r_fault_addr <= req_addr;
                end
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        stall     = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        fault     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid;
                if (req_valid) begin
                    if (!w_valid)
                        w_next = S_FAULT;
                    else if (WAIT_STATES == 0)
                        w_next = S_ACCESS;
                    else
                        w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (r_cnt == c_cnt_w'(1))
                    w_next = S_ACCESS;
            end
            S_ACCESS: begin
                // Gated by reset so an aborted access never reaches the RAM.
                stall  = 1'b1;
                mem_en = !rst;
                mem_we = !rst && r_write;
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (!r_write)
                    rsp_rdata = mem_rdata;
                w_next = S_IDLE;
            end
            S_FAULT: begin
                stall = 1'b1;
                fault = 1'b1;
                if (fault_clr)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign fault_addr = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_mips32_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_mem_bridge
// Brief    : Bench for mips32_mem_bridge at WAIT_STATES 1, 0 and 3 against a
//            transaction-level address/memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips32_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_init;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    // Index 0: WAIT_STATES=1, index 1: WAIT_STATES=0, index 2: WAIT_STATES=3.
    int          waits [3] = '{1, 0, 3};

    logic        req_valid  [3];
    logic        req_write  [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        fault_clr  [3];
    logic        req_ready  [3];
    logic        stall      [3];
    logic        rsp_valid  [3];
    logic [31:0] rsp_rdata  [3];
    logic        fault      [3];
    logic [31:0] fault_addr [3];
    logic        mem_en     [3];
    logic        mem_we     [3];
    logic [10:0] mem_addr   [3];
    logic [31:0] mem_wdata  [3];
    logic [31:0] mem_rdata  [3];

    logic [31:0] ram [3][2048];
    logic [31:0] mdl_mem [logic [63:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips32_mem_bridge #(.WAIT_STATES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .stall(stall[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .fault(fault[0]),
        .fault_addr(fault_addr[0]), .fault_clr(fault_clr[0]), .mem_en(mem_en[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    mips32_mem_bridge #(.WAIT_STATES(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .stall(stall[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .fault(fault[1]),
        .fault_addr(fault_addr[1]), .fault_clr(fault_clr[1]), .mem_en(mem_en[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    mips32_mem_bridge #(.WAIT_STATES(3)) u_dut_w3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_write(req_write[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .req_ready(req_ready[2]), .stall(stall[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .fault(fault[2]),
        .fault_addr(fault_addr[2]), .fault_clr(fault_clr[2]), .mem_en(mem_en[2]),
        .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
        .mem_rdata(mem_rdata[2])
    );

    function automatic logic [31:0] init_word(input int p);
        return 32'hC0DE0000 | 32'(p);
    endfunction

    // Synchronous RAM per bridge, read data one cycle after the strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ram_init) begin
                for (int a = 0; a < 2048; a++) ram[k][a] <= init_word(a);
            end else if (mem_en[k]) begin
                if (mem_we[k]) ram[k][mem_addr[k]] <= mem_wdata[k];
                else           mem_rdata[k] <= ram[k][mem_addr[k]];
            end
        end
    end

    // Virtual byte address -> physical word, straight from the region rules.
    function automatic bit model_map(input logic [31:0] addr, output int ph);
        logic [31:0] base;
        ph = 0;
        if (addr[1:0] != 2'b00) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            base = (i == 0) ? 32'h10010000 : 32'h7FFFE000;
            if (addr >= base && (addr - base) < 32'd4096) begin
                ph = i * 1024 + int'((addr - base) / 4);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on bridge k, starting and ending at a drive point.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit clr_early, output int acc);
        int          ph;
        bit          ok;
        int          nhold;
        logic [63:0] key;
        logic [31:0] exp_rd;
        ok  = model_map(addr, ph);
        key = {k[31:0], addr};
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        fault_clr[k] = clr_early;
        @(negedge clk);
        chk("idle_ready", req_ready[k], 1);
        chk("idle_stall", stall[k], 1);
        chk("idle_mem_en", mem_en[k], 0);
        step();
        acc = cyc;
        fault_clr[k] = 1'b0;
        if (ok) begin
            for (int c = 0; c < waits[k]; c++) begin
                fault_clr[k] = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("wait_stall", stall[k], 1);
                chk("wait_ready", req_ready[k], 0);
                chk("wait_mem_en", mem_en[k], 0);
                chk("wait_rsp", rsp_valid[k], 0);
                step();
            end
            @(negedge clk);
            chk("acc_mem_en", mem_en[k], 1);
            chk("acc_mem_we", mem_we[k], {31'd0, wr});
            chk("acc_mem_addr", {21'd0, mem_addr[k]}, 32'(ph));
            chk("acc_stall", stall[k], 1);
            chk("acc_rsp", rsp_valid[k], 0);
            if (wr) begin
                chk("acc_wdata", mem_wdata[k], wd);
                mdl_mem[key] = wd;
            end
            step();
            fault_clr[k] = 1'b0;
            @(negedge clk);
            if (wr)                       exp_rd = 32'd0;
            else if (mdl_mem.exists(key)) exp_rd = mdl_mem[key];
            else                          exp_rd = init_word(ph);
            chk("rsp_valid", rsp_valid[k], 1);
            chk("rsp_rdata", rsp_rdata[k], exp_rd);
            chk("rsp_stall", stall[k], 0);
            chk("rsp_mem_en", mem_en[k], 0);
            step();
            req_valid[k] = 1'b0;
        end else begin
            nhold = $urandom_range(1, 3);
            for (int h = 0; h <= nhold; h++) begin
                fault_clr[k] = (h == nhold);
                @(negedge clk);
                chk("flt_fault", fault[k], 1);
                chk("flt_addr", fault_addr[k], addr);
                chk("flt_stall", stall[k], 1);
                chk("flt_ready", req_ready[k], 0);
                chk("flt_mem_en", mem_en[k], 0);
                chk("flt_rsp", rsp_valid[k], 0);
                step();
            end
            fault_clr[k] = 1'b0;
            req_valid[k] = 1'b0;
            @(negedge clk);
            chk("clr_fault", fault[k], 0);
            chk("clr_ready", req_ready[k], 1);
            chk("clr_stall", stall[k], 0);
            chk("clr_addr_held", fault_addr[k], addr);
            step();
        end
    endtask

    int          acc0, acc1, kk, cat, nidle;
    logic [31:0] a, d;
    bit          w;

    initial begin
        rst      = 1'b1;
        ram_init = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0;   fault_clr[k] = 1'b0;
        end
        step();
        step();
        rst      = 1'b0;
        ram_init = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", req_ready[k], 1);
            chk("rst_stall", stall[k], 0);
            chk("rst_fault", fault[k], 0);
            chk("rst_mem_en", mem_en[k], 0);
            chk("rst_mem_we", mem_we[k], 0);
            chk("rst_rsp", rsp_valid[k], 0);
            chk("rst_rdata", rsp_rdata[k], 0);
            chk("rst_mem_addr", {21'd0, mem_addr[k]}, 0);
            chk("rst_wdata", mem_wdata[k], 0);
            chk("rst_faddr", fault_addr[k], 0);
        end
        step();

        // Directed region mapping and fault cases.
        xfer(0, 1'b1, 32'h10010008, 32'hDEADBEEF, 1'b0, acc0);
        xfer(0, 1'b0, 32'h10010008, 32'h0, 1'b0, acc0);
        xfer(0, 1'b1, 32'h7FFFE00C, 32'h0BADF00D, 1'b0, acc0);
        xfer(0, 1'b0, 32'h7FFFEFFC, 32'h0, 1'b0, acc0);
        xfer(0, 1'b0, 32'h7FFFE00C, 32'h0, 1'b0, acc0);
        xfer(0, 1'b0, 32'h10010FFC, 32'h0, 1'b0, acc0);
        xfer(0, 1'b0, 32'h10011000, 32'h0, 1'b0, acc0);
        xfer(0, 1'b1, 32'h10010002, 32'h12345678, 1'b0, acc0);
        xfer(0, 1'b0, 32'h00000000, 32'h0, 1'b1, acc0);

        // Back-to-back throughput at 0 and 3 wait states.
        for (int k = 1; k < 3; k++) begin
            xfer(k, 1'b0, 32'h10010004, 32'h0, 1'b0, acc0);
            xfer(k, 1'b0, 32'h7FFFE008, 32'h0, 1'b0, acc1);
            chk("b2b_gap", 32'(acc1 - acc0), 32'(waits[k] + 3));
        end

        // Reset during ACCESS of a store: the RAM must keep its old word.
        xfer(0, 1'b1, 32'h10010010, 32'h11112222, 1'b0, acc0);
        req_valid[0] = 1'b1; req_write[0] = 1'b1;
        req_addr[0]  = 32'h10010010; req_wdata[0] = 32'h33334444;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstacc_mem_en", mem_en[0], 0);
        chk("rstacc_mem_we", mem_we[0], 0);
        step();
        rst = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rstacc_ready", req_ready[0], 1);
        chk("rstacc_stall", stall[0], 0);
        step();
        xfer(0, 1'b0, 32'h10010010, 32'h0, 1'b0, acc0);

        // Reset while a fault is pending.
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h20000000;
        step();
        @(negedge clk);
        chk("rstflt_fault_set", fault[0], 1);
        step();
        rst = 1'b1;
        req_valid[0] = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstflt_fault", fault[0], 0);
        chk("rstflt_faddr", fault_addr[0], 0);
        chk("rstflt_ready", req_ready[0], 1);
        step();

        // Randomized mix of loads, stores and invalid accesses.
        for (int n = 0; n < 80; n++) begin
            kk  = $urandom_range(0, 2);
            cat = $urandom_range(0, 9);
            w   = 1'($urandom_range(0, 1));
            d   = $urandom;
            case (cat)
                0, 1, 2, 3: a = 32'h10010000 + 32'($urandom_range(0, 31)) * 4;
                4, 5, 6:    a = 32'h7FFFE000 + 32'($urandom_range(0, 31)) * 4;
                7:          a = ($urandom_range(0, 1) == 0) ? 32'h10010FFC : 32'h7FFFEFFC;
                8: begin
                    case ($urandom_range(0, 3))
                        0:       a = 32'h1000FFFC;
                        1:       a = 32'h7FFFF000;
                        2:       a = 32'h7FFFDFFC;
                        default: a = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
                    endcase
                end
                default:    a = 32'h10010000 + 32'($urandom_range(0, 31)) * 4
                                + 32'($urandom_range(1, 3));
            endcase
            xfer(kk, w, a, d, 1'($urandom_range(0, 1)), acc0);
            nidle = $urandom_range(0, 2);
            for (int i = 0; i < nidle; i++) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
